led_pattern_gen: RTL and testbench
==================================

# led_pattern_gen

Parametrised LED pattern engine: a step timer advances an LED_NUM-wide pattern once every CNT_MAX clocks, in one of four run-time selectable modes (rotate left, rotate right, ping-pong, blink-all), with pause and a per-step strobe. It drives the board LED bank directly and replaces the fixed 8-LED rotating chaser in board bring-up and demo top levels. An optional PWM stage dims the whole bank.

## Interface
- LED_NUM, 8, number of LEDs / pattern width (≥1)
- CNT_MAX, 13_500_000, clocks per pattern step (≥2)
- CNT_W, $clog2(CNT_MAX), step counter width (derived, not overridden)
- clk  input  1  system clock; one clock domain, all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- mode_i  input  2  requested mode: 0 ROL, 1 ROR, 2 PING, 3 BLINK
- pause_i  input  1  high: step counter and pattern hold
- brightness_i  input  4  PWM duty, 0..15 (present only with LED_PWM_EN)
- led  output  LED_NUM  LED drive, 1 = on
- step_o  output  1  one-cycle pulse on every pattern update
- mode_o  output  2  mode currently in effect

## Operation
- Step counter: counts 0..CNT_MAX-1 and wraps; tick = (cnt == CNT_MAX-1) && !pause_i. With pause_i high the counter holds its value.
- On tick:
  - mode_i != mode_o: load the seed for mode_i, set mode_o = mode_i.
  - Otherwise advance the pattern.
- Seeds: ROL bit0; ROR bit LED_NUM-1; PING bit0 with dir=up; BLINK all ones.
- Advance rules:
  - ROL: {p[N-2:0], p[N-1]}.
  - ROR: {p[0], p[N-1:1]}.
  - PING: shift toward the MSB while dir=up; when bit N-1 is reached, dir flips down and the next step goes to N-2. Mirror at bit0. Sequence for N=4: 0,1,2,3,2,1,0,1…; no end LED repeats.
  - BLINK: pattern = ~pattern.
- LED_NUM=1: ROL/ROR/PING hold the single bit set; BLINK toggles.
- mode_i is sampled only at a tick; changes between ticks have no effect until the next tick.
- Reset values: pattern = bit0 only, mode_o = 0 (ROL), dir = up, cnt = 0, step_o = 0, led = 1 (PWM counter = 0).

## Timing
- Pattern, mode_o and step_o are registered and update in the cycle after the tick condition, together.
- From reset release, the first update is on the CNT_MAX-th clock. Steady-state period is exactly CNT_MAX clocks.
- Pause asserted on the tick cycle suppresses that tick. Release resumes from the held count.
- rst mid-step overrides everything in the same edge, including a concurrent tick.
- Without PWM, led = pattern (zero added latency).

## Configuration
- LED_PWM_EN defined:
  - brightness_i port is present.
  - A 4-bit free-running pwm_cnt runs; led = pattern & {LED_NUM{pwm_cnt < duty}}.
  - duty is brightness_i captured when pwm_cnt == 15, so it is glitch-free and applies from the next PWM frame.
  - duty resets to 15; 0 = dark, 15 = 15/16 on.
  - led is registered, adding 1 cycle of latency vs. pattern.
- LED_PWM_EN undefined: no port, no PWM logic, led = pattern.

## Structure
- Package led_pkg: mode constants MODE_ROL/ROR/PING/BLINK (2-bit), PWM_W = 4.
- Sub-module led_step_timer (params CNT_MAX; ports clk, rst, pause_i, tick_o) holds the prescaler. The top holds the pattern/mode/dir registers and the optional PWM stage.

## Test plan
- LED_NUM=8, CNT_MAX=4, mode 0 after reset -> led 01,02,04…80,01, each held 4 clocks; step_o pulses every 4th clock.
- mode_i=1 mid-step -> unchanged until the tick; then led=80, mode_o=1; subsequent steps 40,20…
- mode 2, LED_NUM=4 -> led 1,2,4,8,4,2,1,2; no repeat at 8 or 1.
- mode 3 -> led FF,00,FF alternating every 4 clocks. Pause for 10 clocks -> led and step_o frozen; period resumes from the held count.
- rst asserted on a tick cycle -> next cycle led=01, mode_o=0, step_o=0, counter restarts.
- LED_PWM_EN, brightness_i=4, mode 3 with led FF -> led high for 4 of every 16 clocks. brightness change mid-frame takes effect at the next frame.

Source files
------------

// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED pattern engine.
//   MODE_ROL/ROR/PING/BLINK : 2-bit mode encodings seen on mode_i/mode_o
//   PWM_W                   : width of the PWM counter and brightness value
//   dir_e                   : ping-pong travel direction
// ---------------------------------------------------------------------------
package led_pkg;

  localparam logic [1:0] MODE_ROL   = 2'd0;
  localparam logic [1:0] MODE_ROR   = 2'd1;
  localparam logic [1:0] MODE_PING  = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  localparam int PWM_W = 4;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/led_step_timer.sv
// ---------------------------------------------------------------------------
// led_step_timer
// Prescaler that produces one tick every CNT_MAX clocks while not paused.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   pause_i : high holds the count and suppresses the tick
//   tick_o  : high for the cycle in which the count sits at CNT_MAX-1
//             and pause_i is low
// ---------------------------------------------------------------------------
module led_step_timer #(
  parameter int CNT_MAX = 13_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic pause_i,
  output logic tick_o
);
  import led_pkg::*;

  localparam int CNT_W = $clog2(CNT_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_max_s;

  assign at_max_s = (cnt_q == CNT_W'(CNT_MAX - 1));
  // Combinational on purpose: the top registers the consequence of the tick.
  assign tick_o   = at_max_s && !pause_i;

  // Next count: hold while paused, wrap at the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (pause_i) begin
      cnt_d = cnt_q;
    end else if (at_max_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
// LED pattern engine: advances an LED_NUM-wide pattern once every CNT_MAX
// clocks in one of four modes (rotate left, rotate right, ping-pong,
// blink-all). A requested mode change takes effect at the next step by
// loading that mode's seed pattern.
//   clk          : system clock
//   rst          : synchronous active-high reset
//   mode_i       : requested mode (sampled only at a step)
//   pause_i      : freezes the step timer and pattern
//   brightness_i : PWM duty 0..15 (only when LED_PWM_EN is defined)
//   led          : LED drive, 1 = on
//   step_o       : one-cycle pulse on each pattern update
//   mode_o       : mode currently in effect
// Build option: define LED_PWM_EN to add the 16-step PWM dimmer; led is
// then registered and lags the pattern by one clock.
// ---------------------------------------------------------------------------
module led_pattern_gen #(
  parameter int LED_NUM = 8,
  parameter int CNT_MAX = 13_500_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode_i,
  input  logic               pause_i,
`ifdef LED_PWM_EN
  input  logic [3:0]         brightness_i,
`endif
  output logic [LED_NUM-1:0] led,
  output logic               step_o,
  output logic [1:0]         mode_o
);
  import led_pkg::*;

  localparam logic [LED_NUM-1:0] SEED_LSB = LED_NUM'(1);
  localparam logic [LED_NUM-1:0] SEED_MSB = LED_NUM'(1) << (LED_NUM - 1);
  localparam logic [LED_NUM-1:0] ALL_ON   = {LED_NUM{1'b1}};

  logic               tick_s;
  logic [LED_NUM-1:0] pat_q,  pat_d;
  logic [1:0]         mode_q, mode_d;
  dir_e               dir_q,  dir_d;
  logic               step_q;
  logic [LED_NUM-1:0] rol_s, ror_s;

  led_step_timer #(
    .CNT_MAX (CNT_MAX)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .pause_i (pause_i),
    .tick_o  (tick_s)
  );

  // Rotations written with modular indexing so LED_NUM = 1 degenerates to a hold.
  always_comb begin
    rol_s = '0;
    ror_s = '0;
    for (int i = 0; i < LED_NUM; i++) begin
      rol_s[i] = pat_q[(i + LED_NUM - 1) % LED_NUM];
      ror_s[i] = pat_q[(i + 1) % LED_NUM];
    end
  end

  // Next pattern/mode/direction: seed on a mode change, otherwise advance.
  always_comb begin
    pat_d  = pat_q;
    mode_d = mode_q;
    dir_d  = dir_q;
    if (!tick_s) begin
      pat_d = pat_q;
    end else if (mode_i != mode_q) begin
      mode_d = mode_i;
      dir_d  = DIR_UP;
      case (mode_i)
        MODE_ROL:   pat_d = SEED_LSB;
        MODE_ROR:   pat_d = SEED_MSB;
        MODE_PING:  pat_d = SEED_LSB;
        MODE_BLINK: pat_d = ALL_ON;
        default:    pat_d = SEED_LSB;
      endcase
    end else begin
      case (mode_q)
        MODE_ROL:   pat_d = rol_s;
        MODE_ROR:   pat_d = ror_s;
        MODE_PING: begin
          // Turn around at either end so no end LED is shown twice in a row.
          if (LED_NUM == 1) begin
            pat_d = pat_q;
          end else if (dir_q == DIR_UP) begin
            if (pat_q[LED_NUM-1]) begin
              pat_d = pat_q >> 1;
              dir_d = DIR_DOWN;
            end else begin
              pat_d = pat_q << 1;
            end
          end else begin
            if (pat_q[0]) begin
              pat_d = pat_q << 1;
              dir_d = DIR_UP;
            end else begin
              pat_d = pat_q >> 1;
            end
          end
        end
        MODE_BLINK: pat_d = ~pat_q;
        default:    pat_d = SEED_LSB;
      endcase
    end
  end

  // Pattern, mode, direction and step strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= SEED_LSB;
      mode_q <= MODE_ROL;
      dir_q  <= DIR_UP;
      step_q <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
      step_q <= tick_s;
    end
  end

  assign step_o = step_q;
  assign mode_o = mode_q;

`ifdef LED_PWM_EN
  logic [PWM_W-1:0]   pwm_cnt_q;
  logic [PWM_W-1:0]   duty_q;
  logic [LED_NUM-1:0] led_q;

  // PWM stage: duty is latched only at the frame end so a frame never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      duty_q    <= {PWM_W{1'b1}};
      led_q     <= SEED_LSB;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
      if (pwm_cnt_q == {PWM_W{1'b1}}) begin
        duty_q <= brightness_i;
      end else begin
        duty_q <= duty_q;
      end
      led_q <= pat_q & {LED_NUM{pwm_cnt_q < duty_q}};
    end
  end

  assign led = led_q;
`else
  assign led = pat_q;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_gen
// Two instances (8 LEDs / 4-clock step, 4 LEDs / 3-clock step) share one
// stimulus stream. The reference model tracks the lit LED as an index plus a
// direction (or an on/off flag for blink) and the clocks elapsed in a step.
// ---------------------------------------------------------------------------
module tb_led_pattern_gen;

  localparam int N0 = 8;
  localparam int C0 = 4;
  localparam int N1 = 4;
  localparam int C1 = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode_i;
  logic       pause_i;
`ifdef LED_PWM_EN
  logic [3:0] brightness_i;
`endif
  logic [N0-1:0] led0;
  logic [N1-1:0] led1;
  logic          step0, step1;
  logic [1:0]    mode0, mode1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_pattern_gen #(.LED_NUM(N0), .CNT_MAX(C0)) dut0 (
    .clk(clk), .rst(rst), .mode_i(mode_i), .pause_i(pause_i),
`ifdef LED_PWM_EN
    .brightness_i(brightness_i),
`endif
    .led(led0), .step_o(step0), .mode_o(mode0)
  );

  led_pattern_gen #(.LED_NUM(N1), .CNT_MAX(C1)) dut1 (
    .clk(clk), .rst(rst), .mode_i(mode_i), .pause_i(pause_i),
`ifdef LED_PWM_EN
    .brightness_i(brightness_i),
`endif
    .led(led1), .step_o(step1), .mode_o(mode1)
  );

  // reference model state, one slot per instance
  int nled[2] = '{N0, N1};
  int cmax[2] = '{C0, C1};
  int m_pos[2], m_up[2], m_on[2], m_mode[2], m_cnt[2], m_step[2];
  int m_led[2];
  int m_pcnt, m_duty;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pat_of(input int k);
    if (m_mode[k] == 3) return m_on[k] != 0 ? (1 << nled[k]) - 1 : 0;
    return 1 << m_pos[k];
  endfunction

  // one rising edge of the model, using the inputs present before the edge
  task automatic model_edge();
    int pprev[2];
    for (int k = 0; k < 2; k++) pprev[k] = pat_of(k);
    for (int k = 0; k < 2; k++) begin
      bit tk;
      tk = (m_cnt[k] == cmax[k] - 1) && !pause_i;
      if (rst) begin
        m_pos[k] = 0; m_up[k] = 1; m_on[k] = 0; m_mode[k] = 0;
        m_cnt[k] = 0; m_step[k] = 0;
      end else begin
        if (!pause_i) m_cnt[k] = (m_cnt[k] + 1) % cmax[k];
        if (tk) begin
          if (int'(mode_i) != m_mode[k]) begin
            m_mode[k] = int'(mode_i);
            m_up[k] = 1;
            m_on[k] = 1;
            m_pos[k] = (mode_i == 2'd1) ? nled[k] - 1 : 0;
          end else begin
            case (m_mode[k])
              0: m_pos[k] = (m_pos[k] + 1) % nled[k];
              1: m_pos[k] = (m_pos[k] + nled[k] - 1) % nled[k];
              2: begin
                if (m_up[k] != 0) begin
                  if (m_pos[k] == nled[k] - 1) begin m_up[k] = 0; m_pos[k]--; end
                  else m_pos[k]++;
                end else begin
                  if (m_pos[k] == 0) begin m_up[k] = 1; m_pos[k]++; end
                  else m_pos[k]--;
                end
              end
              default: m_on[k] = 1 - m_on[k];
            endcase
          end
        end
        m_step[k] = tk ? 1 : 0;
      end
    end
`ifdef LED_PWM_EN
    if (rst) begin
      m_pcnt = 0; m_duty = 15; m_led[0] = 1; m_led[1] = 1;
    end else begin
      for (int k = 0; k < 2; k++) m_led[k] = (m_pcnt < m_duty) ? pprev[k] : 0;
      if (m_pcnt == 15) m_duty = int'(brightness_i);
      m_pcnt = (m_pcnt + 1) % 16;
    end
`else
    for (int k = 0; k < 2; k++) m_led[k] = pat_of(k);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk_eq("led0",  int'(led0),  m_led[0]);
    chk_eq("step0", int'(step0), m_step[0]);
    chk_eq("mode0", int'(mode0), m_mode[0]);
    chk_eq("led1",  int'(led1),  m_led[1]);
    chk_eq("step1", int'(step1), m_step[1]);
    chk_eq("mode1", int'(mode1), m_mode[1]);
  endtask

  initial begin
    rst = 1'b1; mode_i = 2'd0; pause_i = 1'b0;
`ifdef LED_PWM_EN
    brightness_i = 4'd4;
`endif
    m_pcnt = 0; m_duty = 15;
    cycle();
    cycle();
    // reset values against fixed constants
    chk_eq("rst_led0",  int'(led0),  1);
    chk_eq("rst_mode0", int'(mode0), 0);
    chk_eq("rst_step0", int'(step0), 0);
    rst = 1'b0;

    // directed mode sweep, including a change requested mid-step
    for (int i = 0; i < 40; i++) cycle();
    cycle(); cycle();
    mode_i = 2'd1;
    for (int i = 0; i < 40; i++) cycle();
    mode_i = 2'd2;
    for (int i = 0; i < 60; i++) cycle();
    mode_i = 2'd3;
    for (int i = 0; i < 40; i++) cycle();

    // pause for 10 clocks, then resume
    pause_i = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    pause_i = 1'b0;
    for (int i = 0; i < 20; i++) cycle();

    // reset on a tick cycle of instance 0
    begin
      int guard = 0;
      while (m_cnt[0] != C0 - 1 && guard < 20) begin cycle(); guard++; end
      chk_eq("tick_found", guard < 20 ? 1 : 0, 1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk_eq("rst_tick_led0",  int'(led0),  1);
      chk_eq("rst_tick_step0", int'(step0), 0);
      chk_eq("rst_tick_mode0", int'(mode0), 0);
      for (int i = 0; i < 10; i++) cycle();
    end

    // randomized phase
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15, 0) == 0) mode_i = 2'($urandom_range(3, 0));
      pause_i = ($urandom_range(7, 0) == 0);
      rst = ($urandom_range(199, 0) == 0);
`ifdef LED_PWM_EN
      if ($urandom_range(19, 0) == 0) brightness_i = 4'($urandom_range(15, 0));
`endif
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
